// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash buffer model: opcodes, FSM states,
// output lane modes and a helper giving the last beat index of a byte per mode.
package spi_flash_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OP_READ      = 8'h03;
    localparam logic [BYTE_W-1:0] OP_FAST_READ = 8'h0B;
    localparam logic [BYTE_W-1:0] OP_DOR       = 8'h3B;
    localparam logic [BYTE_W-1:0] OP_QOR       = 8'h6B;
    localparam logic [BYTE_W-1:0] OP_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SINGLE,
        DUAL,
        QUAD
    } lane_mode_e;

    // Index of the final SCLK beat that completes one byte in the given mode.
    function automatic logic [2:0] last_beat(input lane_mode_e mode);
        case (mode)
            DUAL:    return 3'd3;
            QUAD:    return 3'd1;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end for the SPI pins.
//   clk, rst            : system clock, async active-high reset
//   cs_i, sclk_i, io_i  : raw pins
//   cs_rise_c/cs_fall_c : one-clk strobes, SYNC_STAGES clk after the pin edge
//   sclk_rise_c/_fall_c : same for SCLK
//   io_o                : io_i through the same synchroniser depth, so it lines
//                         up with the SCLK strobes
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_i,
    input  logic       sclk_i,
    input  logic [3:0] io_i,
    output logic       cs_rise_c,
    output logic       cs_fall_c,
    output logic       sclk_rise_c,
    output logic       sclk_fall_c,
    output logic [3:0] io_o
);

    logic [SYNC_STAGES-1:0]      cs_sync_q;
    logic [SYNC_STAGES-1:0]      sclk_sync_q;
    logic [SYNC_STAGES-1:0][3:0] io_sync_q;
    logic                        cs_prev_q;
    logic                        sclk_prev_q;

    // CS resets high (deselected) so leaving reset never looks like a CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            io_sync_q   <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q[0]   <= cs_i;
            sclk_sync_q[0] <= sclk_i;
            io_sync_q[0]   <= io_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync_q[i]   <= cs_sync_q[i-1];
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                io_sync_q[i]   <= io_sync_q[i-1];
            end
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    // Strobes are combinational off the last stage to keep latency at SYNC_STAGES.
    assign cs_rise_c   =  cs_sync_q[SYNC_STAGES-1]   & ~cs_prev_q;
    assign cs_fall_c   = ~cs_sync_q[SYNC_STAGES-1]   &  cs_prev_q;
    assign sclk_rise_c =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign io_o        = io_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_buffer_model.sv
// SPI NOR flash model serving a static byte buffer (READ, FAST_READ, dual and
// quad output read, JEDEC ID).
//   clk, rst : system clock, async active-high reset
//   cs, sclk : chip select (active low) and SPI mode-0 clock, oversampled
//   io_in    : IO0..IO3 from the controller (only IO0 is consumed)
//   io_out   : registered lane drive values
//   io_oe    : registered lane output enables
//   buffer   : flash contents, byte n = buffer[8n+7:8n]
module spi_flash_buffer_model
    import spi_flash_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE  = 512,
    parameter int unsigned ADDR_BYTES   = 3,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   sclk,
    input  logic [3:0]             io_in,
    output logic [3:0]             io_out,
    output logic [3:0]             io_oe,
    input  logic [BUFFER_SIZE-1:0] buffer
);

    localparam int unsigned AW      = ADDR_BYTES * 8;
    localparam int unsigned NBYTES  = BUFFER_SIZE / 8;
    localparam int unsigned CNT_MAX = (AW > DUMMY_CYCLES) ? AW : DUMMY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic       cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [3:0] io_s;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .cs_i        (cs),
        .sclk_i      (sclk),
        .io_i        (io_in),
        .cs_rise_c   (cs_rise),
        .cs_fall_c   (cs_fall),
        .sclk_rise_c (sclk_rise),
        .sclk_fall_c (sclk_fall),
        .io_o        (io_s)
    );

    // Only single-lane input (opcode/address on IO0) is decoded.
    logic unused_io;
    assign unused_io = ^io_s[3:1];

    state_e          state_q, state_d;
    lane_mode_e      mode_q, mode_d;
    logic            dummy_q, dummy_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      beat_q, beat_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [3:0]      io_out_q, io_out_d;
    logic [3:0]      io_oe_q, io_oe_d;

    logic [7:0]      opcode_c;
    logic [7:0]      mem_byte_c;
    logic [7:0]      id_byte_c;
    logic [7:0]      out_byte_c;

    // Buffer byte mux; addresses past the buffer read as erased flash.
    always_comb begin
        mem_byte_c = 8'hFF;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (addr_q == AW'(i)) mem_byte_c = buffer[8*i +: 8];
        end
    end

    // In ID the address register is a byte index that saturates at 3.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    id_byte_c = JEDEC_ID[23:16];
            2'd1:    id_byte_c = JEDEC_ID[15:8];
            2'd2:    id_byte_c = JEDEC_ID[7:0];
            default: id_byte_c = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= SINGLE;
            dummy_q  <= 1'b0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            shreg_q  <= '0;
            io_out_q <= '0;
            io_oe_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dummy_q  <= dummy_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            shreg_q  <= shreg_d;
            io_out_q <= io_out_d;
            io_oe_q  <= io_oe_d;
        end
    end

    // Next-state and output logic; CS rise overrides everything.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dummy_d    = dummy_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        shreg_d    = shreg_q;
        io_out_d   = io_out_q;
        io_oe_d    = io_oe_q;
        opcode_c   = {cmd_q[6:0], io_s[0]};
        out_byte_c = shreg_q;

        if (cs_rise) begin
            state_d  = IDLE;
            mode_d   = SINGLE;
            dummy_d  = 1'b0;
            cmd_d    = '0;
            cnt_d    = '0;
            addr_d   = '0;
            beat_d   = '0;
            shreg_d  = '0;
            io_out_d = '0;
            io_oe_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cmd_d   = '0;
                        cnt_d   = '0;
                        // An SCLK rise seen with the CS fall is the first opcode bit.
                        if (sclk_rise) begin
                            cmd_d = {7'b0, io_s[0]};
                            cnt_d = CNT_W'(1);
                        end
                    end
                end

                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = opcode_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            addr_d  = '0;
                            beat_d  = '0;
                            mode_d  = SINGLE;
                            dummy_d = 1'b1;
                            case (opcode_c)
                                OP_READ: begin
                                    state_d = ADDR;
                                    dummy_d = 1'b0;
                                end
                                OP_FAST_READ: state_d = ADDR;
                                OP_DOR: begin
                                    state_d = ADDR;
                                    mode_d  = DUAL;
                                end
                                OP_QOR: begin
                                    state_d = ADDR;
                                    mode_d  = QUAD;
                                end
                                OP_RDID: state_d = ID;
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end

                ADDR: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[AW-2:0], io_s[0]};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(AW - 1)) begin
                            cnt_d   = '0;
                            beat_d  = '0;
                            state_d = (dummy_q && (DUMMY_CYCLES > 0)) ? DUMMY : DATA;
                        end
                    end
                end

                DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = DATA;
                        end
                    end
                end

                DATA, ID: begin
                    if (sclk_fall) begin
                        // Beat 0 fetches a fresh byte and advances the address.
                        if (beat_q == 3'd0) begin
                            out_byte_c = (state_q == ID) ? id_byte_c : mem_byte_c;
                            if (state_q == DATA || addr_q < AW'(3)) begin
                                addr_d = addr_q + AW'(1);
                            end
                        end
                        beat_d = (beat_q == last_beat(mode_q)) ? 3'd0 : beat_q + 3'd1;
                        case (mode_q)
                            DUAL: begin
                                io_out_d = {2'b00, out_byte_c[7:6]};
                                shreg_d  = {out_byte_c[5:0], 2'b00};
                                io_oe_d  = 4'b0011;
                            end
                            QUAD: begin
                                io_out_d = out_byte_c[7:4];
                                shreg_d  = {out_byte_c[3:0], 4'b0000};
                                io_oe_d  = 4'b1111;
                            end
                            default: begin
                                io_out_d = {2'b00, out_byte_c[7], 1'b0};
                                shreg_d  = {out_byte_c[6:0], 1'b0};
                                io_oe_d  = 4'b0010;
                            end
                        endcase
                    end
                end

                default: ;
            endcase
        end
    end

    assign io_out = io_out_q;
    assign io_oe  = io_oe_q;

endmodule

// File: tb/tb_spi_flash_buffer_model.sv
// Randomised bench for spi_flash_buffer_model against a byte-stream reference.
module tb_spi_flash_buffer_model;
    import spi_flash_pkg::*;

    localparam int unsigned BUFFER_SIZE = 512;
    localparam int unsigned NBYTES      = BUFFER_SIZE / 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cs;
    logic                   sclk;
    logic [3:0]             io_in;
    logic [3:0]             io_out;
    logic [3:0]             io_oe;
    logic [BUFFER_SIZE-1:0] buffer;

    logic [7:0] mem [NBYTES];
    logic [7:0] id_bytes [3];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_flash_buffer_model #(
        .BUFFER_SIZE  (BUFFER_SIZE),
        .ADDR_BYTES   (3),
        .DUMMY_CYCLES (8),
        .JEDEC_ID     (24'hEF4018),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .sclk   (sclk),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .buffer (buffer)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_read(input logic [7:0] op);
        return op inside {OP_READ, OP_FAST_READ, OP_DOR, OP_QOR};
    endfunction

    function automatic int lanes_of(input logic [7:0] op);
        if (op == OP_DOR) return 2;
        if (op == OP_QOR) return 4;
        return 1;
    endfunction

    // Byte idx of the response stream for a command starting at addr.
    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] addr, input int idx);
        logic [23:0] a;
        if (op == OP_RDID) return (idx < 3) ? id_bytes[idx] : 8'h00;
        a = addr + 24'(idx);
        return (a < 24'(NBYTES)) ? mem[a] : 8'hFF;
    endfunction

    // One SCLK period; samples the lanes at the end of the low phase.
    task automatic sclk_cycle(input logic si, output logic [3:0] o, output logic [3:0] oe);
        io_in = {3'($urandom), si};
        repeat (HALF) @(negedge clk);
        o  = io_out;
        oe = io_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int nbeats, input bit end_rst);
        logic [3:0] o, oe, mask, exp_o;
        logic [7:0] b;
        int w, bpb;
        cs = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            sclk_cycle(op[i], o, oe);
            check("oe_cmd", 32'(oe), 32'h0);
        end
        if (is_read(op)) begin
            for (int i = 23; i >= 0; i--) begin
                sclk_cycle(addr[i], o, oe);
                check("oe_addr", 32'(oe), 32'h0);
            end
            if (op != OP_READ) begin
                for (int i = 0; i < 8; i++) begin
                    sclk_cycle(1'b0, o, oe);
                    check("oe_dummy", 32'(oe), 32'h0);
                end
            end
        end
        if (is_read(op) || op == OP_RDID) begin
            w    = lanes_of(op);
            bpb  = 8 / w;
            mask = (w == 1) ? 4'b0010 : (w == 2) ? 4'b0011 : 4'b1111;
            for (int k = 0; k < nbeats; k++) begin
                sclk_cycle(1'b0, o, oe);
                b = exp_byte(op, addr, k / bpb);
                b = b << (w * (k % bpb));
                case (w)
                    1:       exp_o = {2'b00, b[7], 1'b0};
                    2:       exp_o = {2'b00, b[7:6]};
                    default: exp_o = b[7:4];
                endcase
                check("data_oe", 32'(oe), 32'(mask));
                check($sformatf("data op%0h beat%0d", op, k), 32'(o & mask), 32'(exp_o));
            end
        end else begin
            for (int k = 0; k < nbeats; k++) begin
                sclk_cycle(1'b0, o, oe);
                check("oe_ignore", 32'(oe), 32'h0);
            end
        end
        if (end_rst) begin
            rst  = 1'b1;
            cs   = 1'b1;
            sclk = 1'b0;
            #1;
            check("rst_mid_oe", 32'(io_oe), 32'h0);
            check("rst_mid_out", 32'(io_out), 32'h0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            cs = 1'b1;
            repeat (SYNC_STAGES + 1) @(negedge clk);
            check("cs_rel_oe", 32'(io_oe), 32'h0);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] addr;
        rst   = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        io_in = 4'h0;
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h85;
        mem[1] = 8'h44;
        mem[2] = 8'hA6;
        mem[3] = 8'h14;
        id_bytes[0] = 8'hEF;
        id_bytes[1] = 8'h40;
        id_bytes[2] = 8'h18;
        for (int i = 0; i < NBYTES; i++) buffer[8*i +: 8] = mem[i];

        repeat (3) @(negedge clk);
        check("reset_out", 32'(io_out), 32'h0);
        check("reset_oe", 32'(io_oe), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_txn(OP_READ,      24'h000000, 32, 1'b0);
        run_txn(OP_QOR,       24'h000001, 4,  1'b0);
        run_txn(OP_DOR,       24'(NBYTES - 1), 12, 1'b0);
        run_txn(OP_FAST_READ, 24'hFFFFFF, 16, 1'b0);
        run_txn(OP_RDID,      24'h000000, 32, 1'b0);
        run_txn(8'hAB,        24'h000000, 32, 1'b0);
        run_txn(OP_READ,      24'h000000, 3,  1'b0);
        run_txn(OP_READ,      24'h000000, 8,  1'b0);
        run_txn(OP_QOR,       24'h000010, 3,  1'b1);
        run_txn(OP_READ,      24'h000000, 16, 1'b0);

        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 5))
                0: op = OP_READ;
                1: op = OP_FAST_READ;
                2: op = OP_DOR;
                3: op = OP_QOR;
                4: op = OP_RDID;
                default: begin
                    op = 8'($urandom);
                    if (is_read(op) || op == OP_RDID) op = 8'h00;
                end
            endcase
            case ($urandom_range(0, 2))
                0:       addr = 24'($urandom_range(0, NBYTES + 8));
                1:       addr = 24'hFFFFFF - 24'($urandom_range(0, 3));
                default: addr = 24'($urandom);
            endcase
            run_txn(op, addr, $urandom_range(1, 40), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
